pc_fetch_ctrl: RTL and testbench

Fetch-side PC controller: owns the program counter, issues instruction-memory fetch requests, and consumes the branch unit's redirect outputs (PcSel, BrPC, Halt_Insert) returned from EX. It sequences reset start-up, sequential fetch, hazard stalls, taken-branch/JALR redirects with IF/ID and ID/EX flush, and the terminal halt state. It sits between the hazard unit, the branch unit and instruction memory, and feeds Cur_PC into the IF/ID register.

---
 rtl/pc_fetch_ctrl_pkg.sv | 6 +
 rtl/pc_fetch_ctrl_if.sv | 30 +++
 rtl/pc_fetch_ctrl_redirect_counter.sv | 14 +
 rtl/pc_fetch_ctrl.sv | 70 +++++++
 tb/tb_pc_fetch_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-side PC controller.
package pc_fetch_pkg;
  typedef enum logic [1:0] {ST_RST, ST_RUN, ST_HALT} fetch_state_e;
  localparam int PC_INC        = 4;
  localparam int CNT_W_DEFAULT = 16;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch controller bundle: hazard/branch inputs, imem handshake, IF/ID side outputs.
interface pc_fetch_ctrl_if #(
  parameter int PC_W  = 9,
  parameter int CNT_W = pc_fetch_pkg::CNT_W_DEFAULT
);
  logic             PcSel;
  logic [31:0]      BrPC;
  logic             Halt_Insert;
  logic             Stall;
  logic             Imem_Ack;
  logic             Imem_Req;
  logic [PC_W-1:0]  Imem_Addr;
  logic [PC_W-1:0]  Cur_PC;
  logic             IfId_Valid;
  logic             Flush_IfId;
  logic             Flush_IdEx;
  logic             Halted;
  logic [CNT_W-1:0] Redirect_Cnt;

  modport ctrl (
    input  PcSel, BrPC, Halt_Insert, Stall, Imem_Ack,
    output Imem_Req, Imem_Addr, Cur_PC, IfId_Valid, Flush_IfId, Flush_IdEx,
           Halted, Redirect_Cnt
  );
  modport env (
    output PcSel, BrPC, Halt_Insert, Stall, Imem_Ack,
    input  Imem_Req, Imem_Addr, Cur_PC, IfId_Valid, Flush_IfId, Flush_IdEx,
           Halted, Redirect_Cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl_redirect_counter.sv
// Saturating event counter for taken redirects.
module redirect_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (en && cnt != '1)   cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC controller: reset start-up, sequential fetch, stalls, redirects, halt.
// Optional redirect counter enabled by defining PC_REDIRECT_CNT_EN.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  pc_fetch_ctrl_if.ctrl bus
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            run;
  logic            redirect;

  assign run      = (state_q == ST_RUN);
  assign redirect = run && bus.PcSel && !bus.Halt_Insert;

  // Only the word-aligned in-range bits of the target are meaningful.
  logic unused_brpc;
  assign unused_brpc = ^{bus.BrPC[31:PC_W], bus.BrPC[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_RST:  state_d = ST_RUN;
      ST_RUN: begin
        if (bus.Halt_Insert)                  state_d = ST_HALT;
        else if (bus.PcSel)                   pc_d = {bus.BrPC[PC_W-1:2], 2'b00};
        else if (bus.Imem_Ack && !bus.Stall)  pc_d = pc_q + PC_W'(PC_INC);
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    bus.Imem_Req   = run && !bus.Halt_Insert;
    bus.Imem_Addr  = pc_q;
    bus.Cur_PC     = pc_q;
    bus.IfId_Valid = run && bus.Imem_Ack && !bus.Stall && !bus.PcSel && !bus.Halt_Insert;
    bus.Flush_IfId = redirect;
    bus.Flush_IdEx = redirect;
    bus.Halted     = (state_q == ST_HALT);
  end

`ifdef PC_REDIRECT_CNT_EN
  redirect_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (redirect),
    .cnt   (bus.Redirect_Cnt)
  );
`else
  assign bus.Redirect_Cnt = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, hand sequences, randomized model compare.
module tb_pc_fetch_ctrl;
`ifdef PC_REDIRECT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.PC_W(9), .CNT_W(16)) bus ();
  pc_fetch_ctrl #(.PC_W(9), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        pcsel;
    logic [31:0] brpc;
    logic        halt, stall, ack;
    logic        req;
    logic [8:0]  addr;
    logic        valid, flush, halted;
    logic [15:0] cnt;
  } vec_t;
  vec_t vt[$];

  // behavioural model
  int          m_pc;
  bit          m_boot, m_halt;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pcsel, input logic [31:0] brpc,
                       input logic halt, input logic stall, input logic ack);
    bus.PcSel = pcsel; bus.BrPC = brpc; bus.Halt_Insert = halt;
    bus.Stall = stall; bus.Imem_Ack = ack;
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [8:0] addr,
                            input logic valid, input logic flush, input logic halted,
                            input logic [15:0] cnt);
    chk({tag, ".req"},    bus.Imem_Req, req);
    chk({tag, ".addr"},   bus.Imem_Addr, addr);
    chk({tag, ".cur_pc"}, bus.Cur_PC, addr);
    chk({tag, ".valid"},  bus.IfId_Valid, valid);
    chk({tag, ".fl_ifid"},bus.Flush_IfId, flush);
    chk({tag, ".fl_idex"},bus.Flush_IdEx, flush);
    chk({tag, ".halted"}, bus.Halted, halted);
    chk({tag, ".cnt"},    bus.Redirect_Cnt, cnt);
  endtask

  function automatic vec_t mk(logic pcsel, logic [31:0] brpc, logic halt, logic stall,
                              logic ack, logic req, logic [8:0] addr, logic valid,
                              logic flush, logic halted, logic [15:0] cnt);
    vec_t v;
    v.pcsel = pcsel; v.brpc = brpc; v.halt = halt; v.stall = stall; v.ack = ack;
    v.req = req; v.addr = addr; v.valid = valid; v.flush = flush; v.halted = halted;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_boot = 1'b1; m_halt = 1'b0; m_cnt = 0;
  endtask

  task automatic model_check(input string tag);
    bit running;
    running = !m_boot && !m_halt;
    check_outs(tag, running && !bus.Halt_Insert, m_pc[8:0],
               running && !bus.Halt_Insert && !bus.PcSel && !bus.Stall && bus.Imem_Ack,
               running && !bus.Halt_Insert && bus.PcSel, m_halt, m_cnt[15:0]);
  endtask

  // Applied at the negedge; reflects what the following rising edge does.
  task automatic model_step();
    if (m_boot) m_boot = 1'b0;
    else if (!m_halt) begin
      if (bus.Halt_Insert) m_halt = 1'b1;
      else if (bus.PcSel) begin
        m_pc = int'(bus.BrPC & 32'h1FC);
        if (CNT_ON && m_cnt < 65535) m_cnt++;
      end else if (bus.Imem_Ack && !bus.Stall) m_pc = (m_pc + 4) % 512;
    end
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #2;
    check_outs(tag, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] c1, c2;
    int          n_sat;
    c1 = CNT_ON ? 16'd1 : 16'd0;
    c2 = CNT_ON ? 16'd2 : 16'd0;

    // reset asserted with live inputs: everything stays quiet
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 16'h0);

    //          pcsel brpc          halt stall ack  req addr   vld fl  hlt cnt
    vt.push_back(mk(0, 32'h0,        0, 0, 1,      0, 9'h000, 0, 0, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 0, 1,      1, 9'h000, 1, 0, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 0, 1,      1, 9'h004, 1, 0, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 0, 1,      1, 9'h008, 1, 0, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 0, 1,      1, 9'h00C, 1, 0, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 1, 1,      1, 9'h010, 0, 0, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 1, 0,      1, 9'h010, 0, 0, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 1, 1,      1, 9'h010, 0, 0, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 0, 1,      1, 9'h010, 1, 0, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 0, 1,      1, 9'h014, 1, 0, 0, 16'h0));
    vt.push_back(mk(1, 32'h0000_0123, 0, 1, 1,     1, 9'h018, 0, 1, 0, 16'h0));
    vt.push_back(mk(0, 32'h0,        0, 0, 0,      1, 9'h120, 0, 0, 0, c1));
    vt.push_back(mk(1, 32'hFFFF_F1FF, 0, 0, 0,     1, 9'h120, 0, 1, 0, c1));
    vt.push_back(mk(0, 32'h0,        0, 0, 1,      1, 9'h1FC, 1, 0, 0, c2));
    vt.push_back(mk(0, 32'h0,        0, 0, 0,      1, 9'h000, 0, 0, 0, c2));
    vt.push_back(mk(1, 32'h0000_0040, 1, 0, 1,     0, 9'h000, 0, 0, 0, c2));
    vt.push_back(mk(1, 32'h0000_0080, 0, 0, 1,     0, 9'h000, 0, 0, 1, c2));
    vt.push_back(mk(1, 32'h0000_0080, 0, 1, 1,     0, 9'h000, 0, 0, 1, c2));

    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (vt[i]) begin
      drive(vt[i].pcsel, vt[i].brpc, vt[i].halt, vt[i].stall, vt[i].ack);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].valid,
                 vt[i].flush, vt[i].halted, vt[i].cnt);
      @(posedge clk); #1;
    end

    // async reset straight out of halt, redirect inputs still asserted
    async_reset_check("rst_from_halt");

    // randomized run against the model, with occasional mid-operation resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        drive(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        async_reset_check("rst_mid");
      end else begin
        drive($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 63) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        @(negedge clk);
        model_check("rand");
        model_step();
        @(posedge clk); #1;
      end
    end

    // continuous redirects: counter saturates (or stays 0 without the counter)
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    async_reset_check("rst_sat");
    drive(1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b1);
    n_sat = CNT_ON ? 65540 : 40;
    repeat (n_sat + 1) @(posedge clk);
    @(negedge clk);
    chk("sat.cnt", bus.Redirect_Cnt, CNT_ON ? 16'hFFFF : 16'h0);
    chk("sat.addr", bus.Imem_Addr, 9'h044);
    chk("sat.flush", bus.Flush_IfId, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sat.cnt_hold", bus.Redirect_Cnt, CNT_ON ? 16'hFFFF : 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
